// File: rtl/aes_pkg.sv
// Shared constants, FSM/update encodings and GF(2^8) round helpers for the AES encipher datapath.
// Latency: n/a (types, constants and combinational functions only).
// Backpressure: n/a.
// Contents: key-length codes, round counts, control states, update-type codes,
//           gm2/gm3, per-column mixcolumns and whole-state shiftrows/mixcolumns.
package aes_pkg;

    localparam logic       AES_128_BIT_KEY = 1'b0;
    localparam logic       AES_256_BIT_KEY = 1'b1;

    localparam logic [3:0] AES128_ROUNDS   = 4'd10;
    localparam logic [3:0] AES256_ROUNDS   = 4'd14;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_INIT = 2'd1,
        CTRL_SBOX = 2'd2,
        CTRL_MAIN = 2'd3
    } ctrl_state_e;

    typedef enum logic [2:0] {
        NO_UPDATE    = 3'd0,
        INIT_UPDATE  = 3'd1,
        SBOX_UPDATE  = 3'd2,
        MAIN_UPDATE  = 3'd3,
        FINAL_UPDATE = 3'd4
    } update_type_e;

    // Multiply by x in GF(2^8), reduction polynomial 0x11b.
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    // One column; byte [31:24] is row 0.
    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] a, b, c, d;
        a = w[31:24];
        b = w[23:16];
        c = w[15:8];
        d = w[7:0];
        return {gm2(a) ^ gm3(b) ^ c ^ d,
                a ^ gm2(b) ^ gm3(c) ^ d,
                a ^ b ^ gm2(c) ^ gm3(d),
                gm3(a) ^ b ^ c ^ gm2(d)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
    endfunction

    // Row r of column i comes from column (i + r) mod 4.
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [31:0] w0, w1, w2, w3;
        w0 = s[127:96];
        w1 = s[95:64];
        w2 = s[63:32];
        w3 = s[31:0];
        return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
                w1[31:24], w2[23:16], w3[15:8], w0[7:0],
                w2[31:24], w3[23:16], w0[15:8], w1[7:0],
                w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box applied to the four bytes of a 32-bit word.
// Latency: combinational.
// Backpressure: none.
// Ports: sboxw (in, 32) word to substitute; new_sboxw (out, 32) substituted word.
module aes_sbox (
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign new_sboxw = {SBOX[sboxw[31:24]], SBOX[sboxw[23:16]],
                        SBOX[sboxw[15:8]],  SBOX[sboxw[7:0]]};

endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encipher: init AddRoundKey, then per round SubBytes followed by ShiftRows/MixColumns/AddRoundKey.
// Latency: 2 + NR*5 cycles from accepted next to ready (2 + NR*2 with AES_ENC_FOUR_SBOX_EN defined).
// Backpressure: none; next is accepted only while ready is high and ignored otherwise.
// Ports: clk, reset_n (async active-low); next start pulse; keylen 0=AES-128 1=AES-256;
//        round key-memory index out; round_key key for round in; block plaintext in;
//        new_block state/ciphertext out; ready high when idle/done.
// Build option: AES_ENC_FOUR_SBOX_EN substitutes all 16 bytes in one cycle with four S-box words.
module aes_encipher_block
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    ctrl_state_e  ctrl_q, ctrl_d;
    update_type_e update_type;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic         keylen_q, keylen_d;
    logic         ready_q, ready_d;
    logic [3:0]   num_rounds;

`ifdef AES_ENC_FOUR_SBOX_EN
    logic [127:0] sub_state;

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .sboxw     (state_q[32*i +: 32]),
            .new_sboxw (sub_state[32*i +: 32])
        );
    end
`else
    logic [1:0]   sword_ctr_q, sword_ctr_d;
    logic [31:0]  sbox_in, sbox_out;

    // Word 0 is the most significant word, matching the {w0,w1,w2,w3} state layout.
    always_comb begin
        sbox_in = state_q[127:96];
        unique case (sword_ctr_q)
            2'd0: sbox_in = state_q[127:96];
            2'd1: sbox_in = state_q[95:64];
            2'd2: sbox_in = state_q[63:32];
            2'd3: sbox_in = state_q[31:0];
            default: sbox_in = state_q[127:96];
        endcase
    end

    aes_sbox u_sbox (
        .sboxw     (sbox_in),
        .new_sboxw (sbox_out)
    );
`endif

    assign num_rounds = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;

    // Control: sequences rounds and selects which state update happens this cycle.
    always_comb begin
        ctrl_d      = ctrl_q;
        round_ctr_d = round_ctr_q;
        keylen_d    = keylen_q;
        ready_d     = ready_q;
        update_type = NO_UPDATE;
`ifndef AES_ENC_FOUR_SBOX_EN
        sword_ctr_d = sword_ctr_q;
`endif
        unique case (ctrl_q)
            CTRL_IDLE: begin
                if (next) begin
                    round_ctr_d = 4'd0;
                    keylen_d    = keylen;
                    ready_d     = 1'b0;
                    ctrl_d      = CTRL_INIT;
                end
            end
            CTRL_INIT: begin
                update_type = INIT_UPDATE;
                round_ctr_d = 4'd1;
`ifndef AES_ENC_FOUR_SBOX_EN
                sword_ctr_d = 2'd0;
`endif
                ctrl_d      = CTRL_SBOX;
            end
            CTRL_SBOX: begin
                update_type = SBOX_UPDATE;
`ifdef AES_ENC_FOUR_SBOX_EN
                ctrl_d      = CTRL_MAIN;
`else
                // Counter wraps back to 0 on the last word.
                sword_ctr_d = sword_ctr_q + 2'd1;
                if (sword_ctr_q == 2'd3) begin
                    ctrl_d = CTRL_MAIN;
                end
`endif
            end
            CTRL_MAIN: begin
`ifndef AES_ENC_FOUR_SBOX_EN
                sword_ctr_d = 2'd0;
`endif
                if (round_ctr_q < num_rounds) begin
                    update_type = MAIN_UPDATE;
                    round_ctr_d = round_ctr_q + 4'd1;
                    ctrl_d      = CTRL_SBOX;
                end else begin
                    // Final round skips MixColumns; round stays at NR.
                    update_type = FINAL_UPDATE;
                    ready_d     = 1'b1;
                    ctrl_d      = CTRL_IDLE;
                end
            end
            default: ctrl_d = CTRL_IDLE;
        endcase
    end

    // Datapath: round_key always corresponds to the current round index.
    always_comb begin
        state_d = state_q;
        unique case (update_type)
            INIT_UPDATE:  state_d = block ^ round_key;
            SBOX_UPDATE: begin
`ifdef AES_ENC_FOUR_SBOX_EN
                state_d = sub_state;
`else
                unique case (sword_ctr_q)
                    2'd0: state_d[127:96] = sbox_out;
                    2'd1: state_d[95:64]  = sbox_out;
                    2'd2: state_d[63:32]  = sbox_out;
                    2'd3: state_d[31:0]   = sbox_out;
                    default: state_d = state_q;
                endcase
`endif
            end
            MAIN_UPDATE:  state_d = mixcolumns(shiftrows(state_q)) ^ round_key;
            FINAL_UPDATE: state_d = shiftrows(state_q) ^ round_key;
            default:      state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= CTRL_IDLE;
            state_q     <= '0;
            round_ctr_q <= 4'd0;
            keylen_q    <= AES_128_BIT_KEY;
            ready_q     <= 1'b1;
`ifndef AES_ENC_FOUR_SBOX_EN
            sword_ctr_q <= 2'd0;
`endif
        end else begin
            ctrl_q      <= ctrl_d;
            state_q     <= state_d;
            round_ctr_q <= round_ctr_d;
            keylen_q    <= keylen_d;
            ready_q     <= ready_d;
`ifndef AES_ENC_FOUR_SBOX_EN
            sword_ctr_q <= sword_ctr_d;
`endif
        end
    end

    assign round     = round_ctr_q;
    assign new_block = state_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_aes_encipher_block.sv
// Directed FIPS-197 vector bench for aes_encipher_block; the bench expands the key itself
// and serves round_key combinationally from the round index, like the key memory does.
// Latency: expected ready latency depends on AES_ENC_FOUR_SBOX_EN, matching the RTL build.
module tb_aes_encipher_block;

    logic         clk;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    logic [127:0] rk_tab [0:15];

    int n_cmp;
    int n_err;
    logic         mono_ok;
    logic [3:0]   last_round;

`ifdef AES_ENC_FOUR_SBOX_EN
    localparam int LAT128 = 22;
    localparam int LAT256 = 30;
`else
    localparam int LAT128 = 52;
    localparam int LAT256 = 72;
`endif

    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_encipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb round_key = rk_tab[round];

    // S-box derived arithmetically (inverse then affine map) rather than from a table.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv, s;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {ref_sbox(w[31:24]), ref_sbox(w[23:16]), ref_sbox(w[15:8]), ref_sbox(w[7:0])};
    endfunction

    task automatic expand_key(input logic [255:0] key, input logic kl);
        logic [31:0] w [0:63];
        logic [31:0] temp;
        logic [7:0]  rc;
        int nk, nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = subword({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                temp = subword(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r < 16; r++) begin
            rk_tab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        end
    endtask

    // inject: 0 none, 1 busy next pulse + keylen flip at cycle 10, 2 stop at cycle 20.
    // cyc counts clock edges from the one that samples next (cycle 1); -1 on timeout.
    task automatic run_enc(input logic [255:0] key, input logic kl, input logic [127:0] pt,
                           input int inject, output int cyc, output logic [127:0] ct);
        expand_key(key, kl);
        block   = pt;
        keylen  = kl;
        mono_ok = 1'b1;
        @(negedge clk);
        next = 1'b1;
        @(posedge clk);
        #1;
        next       = 1'b0;
        cyc        = 1;
        last_round = round;
        while (ready !== 1'b1 && cyc < 200 && !(inject == 2 && cyc >= 20)) begin
            if (inject == 1 && cyc == 10) begin
                next   = 1'b1;
                keylen = ~keylen;
            end else begin
                next = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (round < last_round) mono_ok = 1'b0;
            last_round = round;
        end
        next = 1'b0;
        if (inject != 2 && ready !== 1'b1) cyc = -1;
        ct = new_block;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b expected 1", ready);
        end
        n_cmp++;
        if (new_block !== 128'h0) begin
            n_err++;
            $display("FAIL reset_new_block: got %h expected 0", new_block);
        end
        n_cmp++;
        if (round !== 4'd0) begin
            n_err++;
            $display("FAIL reset_round: got %0d expected 0", round);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_ready: got %b expected 1", ready);
        end
        n_cmp++;
        if (new_block !== 128'h0) begin
            n_err++;
            $display("FAIL idle_new_block: got %h expected 0", new_block);
        end
        n_cmp++;
        if (round !== 4'd0) begin
            n_err++;
            $display("FAIL idle_round: got %0d expected 0", round);
        end
    endtask

    task automatic test_aes128();
        int cyc;
        logic [127:0] ct;
        run_enc(KEY_C1, 1'b0, PT_C, 0, cyc, ct);
        n_cmp++;
        if (ct !== CT_C1) begin
            n_err++;
            $display("FAIL aes128_ct: got %h expected %h", ct, CT_C1);
        end
        n_cmp++;
        if (cyc != LAT128) begin
            n_err++;
            $display("FAIL aes128_latency: got %0d expected %0d", cyc, LAT128);
        end
        n_cmp++;
        if (round !== 4'd10) begin
            n_err++;
            $display("FAIL aes128_final_round: got %0d expected 10", round);
        end
        // Result must hold while idle with no new request.
        block = ~PT_C;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (new_block !== CT_C1 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL aes128_hold: got %h ready %b expected %h ready 1", new_block, ready, CT_C1);
        end
    endtask

    task automatic test_aes256();
        int cyc;
        logic [127:0] ct;
        run_enc(KEY_C3, 1'b1, PT_C, 0, cyc, ct);
        n_cmp++;
        if (ct !== CT_C3) begin
            n_err++;
            $display("FAIL aes256_ct: got %h expected %h", ct, CT_C3);
        end
        n_cmp++;
        if (cyc != LAT256) begin
            n_err++;
            $display("FAIL aes256_latency: got %0d expected %0d", cyc, LAT256);
        end
        n_cmp++;
        if (mono_ok !== 1'b1) begin
            n_err++;
            $display("FAIL aes256_round_monotonic: got %b expected 1", mono_ok);
        end
        n_cmp++;
        if (round !== 4'd14) begin
            n_err++;
            $display("FAIL aes256_final_round: got %0d expected 14", round);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        logic [127:0] ct;
        run_enc(KEY_B, 1'b0, PT_B, 1, cyc, ct);
        n_cmp++;
        if (ct !== CT_B) begin
            n_err++;
            $display("FAIL busy_ct: got %h expected %h", ct, CT_B);
        end
        n_cmp++;
        if (cyc != LAT128) begin
            n_err++;
            $display("FAIL busy_latency: got %0d expected %0d", cyc, LAT128);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic [127:0] ct;
        run_enc(KEY_C1, 1'b0, PT_C, 2, cyc, ct);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_ready: got %b expected 1", ready);
        end
        n_cmp++;
        if (new_block !== 128'h0) begin
            n_err++;
            $display("FAIL midreset_new_block: got %h expected 0", new_block);
        end
        n_cmp++;
        if (round !== 4'd0) begin
            n_err++;
            $display("FAIL midreset_round: got %0d expected 0", round);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_enc(KEY_B, 1'b0, PT_B, 0, cyc, ct);
        n_cmp++;
        if (ct !== CT_B) begin
            n_err++;
            $display("FAIL restart_ct: got %h expected %h", ct, CT_B);
        end
        n_cmp++;
        if (cyc != LAT128) begin
            n_err++;
            $display("FAIL restart_latency: got %0d expected %0d", cyc, LAT128);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        mono_ok    = 1'b1;
        last_round = 4'd0;
        reset_n    = 1'b0;
        next       = 1'b0;
        keylen     = 1'b0;
        block      = 128'h0;
        for (int r = 0; r < 16; r++) rk_tab[r] = 128'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        test_reset();
        test_aes128();
        test_aes256();
        test_busy_ignore();
        test_reset_mid_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
